// File: rtl/alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_sequencer                                                   |
// | Purpose  : Sequences one ALU instruction (1000rfff) through the relay ALU: |
// |            function select, settle, drive, load strobe and flag capture.   |
// | Options  : define ALUSEQ_PERF_EN to add the op_count completion counter.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_sequencer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  instr,
    input  logic [7:0]  result,
    input  logic        carry_in,
    output logic [2:0]  f,
    output logic        alu_en,
    output logic        ld_a,
    output logic        ld_d,
    output logic        ld_cond,
    output logic [2:0]  cond,
    output logic        busy,
    output logic        done,
    output logic        illegal
`ifdef ALUSEQ_PERF_EN
    ,
    output logic [15:0] op_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_DRIVE  = 2'd2,
        S_LATCH  = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] ALU_OPCODE  = 4'b1000;
    localparam logic [2:0] FN_ADD      = 3'b000;
    localparam logic [2:0] FN_INC      = 3'b001;
    localparam logic [2:0] FN_NOP      = 3'b111;

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [2:0] fsel, fsel_n;
    logic       dst, dst_n;

    logic [2:0] f_n;
    logic [2:0] cond_n;
    logic       alu_en_n;
    logic       ld_a_n;
    logic       ld_d_n;
    logic       ld_cond_n;
    logic       busy_n;
    logic       done_n;
    logic       illegal_n;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        fsel_n    = fsel;
        dst_n     = dst;
        cond_n    = cond;
        done_n    = 1'b0;
        illegal_n = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (instr[7:4] != ALU_OPCODE) begin
                        illegal_n = 1'b1;
                    end else if (instr[2:0] == FN_NOP) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = S_SELECT;
                        cnt_n   = SETTLE_LOAD;
                        fsel_n  = instr[2:0];
                        dst_n   = instr[3];
                    end
                end
            end
            S_SELECT: begin
                if (cnt == 8'd0) begin
                    state_n = S_DRIVE;
                    cnt_n   = SETTLE_LOAD;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            S_DRIVE: begin
                if (cnt == 8'd0) begin
                    state_n = S_LATCH;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            S_LATCH: begin
                state_n = S_IDLE;
                done_n  = 1'b1;
                // Only the adder paths produce a meaningful carry.
                cond_n  = {result[7],
                           carry_in & ((fsel == FN_ADD) || (fsel == FN_INC)),
                           (result == 8'h00)};
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so every port comes straight off a flop.
        f_n       = (state_n == S_IDLE) ? FN_NOP : fsel_n;
        alu_en_n  = (state_n == S_DRIVE) || (state_n == S_LATCH);
        ld_a_n    = (state_n == S_LATCH) && !dst_n;
        ld_d_n    = (state_n == S_LATCH) && dst_n;
        ld_cond_n = (state_n == S_LATCH);
        busy_n    = (state_n != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
            fsel  <= FN_NOP;
            dst   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            fsel  <= fsel_n;
            dst   <= dst_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f       <= FN_NOP;
            alu_en  <= 1'b0;
            ld_a    <= 1'b0;
            ld_d    <= 1'b0;
            ld_cond <= 1'b0;
            cond    <= 3'b000;
            busy    <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            f       <= f_n;
            alu_en  <= alu_en_n;
            ld_a    <= ld_a_n;
            ld_d    <= ld_d_n;
            ld_cond <= ld_cond_n;
            cond    <= cond_n;
            busy    <= busy_n;
            done    <= done_n;
            illegal <= illegal_n;
        end
    end

`ifdef ALUSEQ_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_count <= 16'd0;
        end else if (done_n && (op_count != 16'hFFFF)) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_sequencer                                                |
// | Purpose  : Self-checking bench for alu_sequencer (SETTLE_CYCLES=2), with a |
// |            scoreboard of expected condition flags popped on each done.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_alu_sequencer;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] instr;
    logic [7:0] result;
    logic       carry_in;
    logic [2:0] f;
    logic       alu_en;
    logic       ld_a;
    logic       ld_d;
    logic       ld_cond;
    logic [2:0] cond;
    logic       busy;
    logic       done;
    logic       illegal;
`ifdef ALUSEQ_PERF_EN
    logic [15:0] op_count;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] exp_cond;
    logic [2:0] sb[$];
    logic [2:0] sb_head;
    logic [9:0] obs;

    assign obs = {f, alu_en, ld_a, ld_d, ld_cond, busy, done, illegal};

    always #5 clk = ~clk;

    alu_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .instr    (instr),
        .result   (result),
        .carry_in (carry_in),
        .f        (f),
        .alu_en   (alu_en),
        .ld_a     (ld_a),
        .ld_d     (ld_d),
        .ld_cond  (ld_cond),
        .cond     (cond),
        .busy     (busy),
        .done     (done),
        .illegal  (illegal)
`ifdef ALUSEQ_PERF_EN
        ,
        .op_count (op_count)
`endif
    );

    // Expected {f, alu_en, ld_a, ld_d, ld_cond, busy, done, illegal} in cycle c after a start in cycle 0.
    function automatic logic [9:0] exp_vec(input logic [7:0] ins, input int c);
        logic [2:0] fe  = 3'b111;
        logic       en  = 1'b0;
        logic       la  = 1'b0;
        logic       ldd = 1'b0;
        logic       lc  = 1'b0;
        logic       bz  = 1'b0;
        logic       dn  = 1'b0;
        logic       il  = 1'b0;
        if (ins[7:4] != 4'b1000) begin
            il = (c == 1);
        end else if (ins[2:0] == 3'b111) begin
            dn = (c == 1);
        end else begin
            if (c >= 1 && c <= 2*S+1) begin
                fe = ins[2:0];
                bz = 1'b1;
            end
            en  = (c >= S+1 && c <= 2*S+1);
            la  = (c == 2*S+1) && !ins[3];
            ldd = (c == 2*S+1) && ins[3];
            lc  = (c == 2*S+1);
            dn  = (c == 2*S+2);
        end
        return {fe, en, la, ldd, lc, bz, dn, il};
    endfunction

    function automatic logic [2:0] model_cond(input logic [7:0] ins, input logic [7:0] res, input logic cy);
        return {res[7], cy & (ins[2:1] == 2'b00), (res == 8'h00)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a start and record what the scoreboard should see on the matching done.
    task automatic issue(input logic [7:0] ins, input logic [7:0] res, input logic cy);
        instr    = ins;
        result   = res;
        carry_in = cy;
        start    = 1'b1;
        if (ins[7:4] == 4'b1000) begin
            if (ins[2:0] != 3'b111) exp_cond = model_cond(ins, res, cy);
            sb.push_back(exp_cond);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: done pulse with no pending operation at %0t", $time);
            end else begin
                sb_head = sb.pop_front();
                if (cond !== sb_head) begin
                    n_fail++;
                    $display("FAIL cond_on_done: got %b expected %b at %0t", cond, sb_head, $time);
                end
            end
        end
        if (!reset && (ld_a || ld_d)) begin
            n_checks++;
            if (ld_a && ld_d) begin
                n_fail++;
                $display("FAIL ld_exclusive: ld_a=%b ld_d=%b expected one-hot at %0t", ld_a, ld_d, $time);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; instr = 8'h00; result = 8'h00; carry_in = 1'b0;
        exp_cond = 3'b000;
        @(negedge clk);
        n_checks++;
        if (obs !== 10'b111_0000000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 10'b111_0000000);
        end
        n_checks++;
        if (cond !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_cond: got %b expected 000", cond);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_timing();
        tick();
        issue(8'h80, 8'h00, 1'b1);
        for (int c = 1; c <= 2*S+3; c++) begin
            tick();
            start = 1'b0;
            @(negedge clk);
            n_checks++;
            if (obs !== exp_vec(8'h80, c)) begin
                n_fail++;
                $display("FAIL timing_add_a c=%0d: got %b expected %b", c, obs, exp_vec(8'h80, c));
            end
        end
    endtask

    task automatic test_dest_flags();
        tick();
        issue(8'h8A, 8'h80, 1'b1);
        for (int c = 1; c <= 2*S+3; c++) begin
            tick();
            start = 1'b0;
            @(negedge clk);
            n_checks++;
            if (obs !== exp_vec(8'h8A, c)) begin
                n_fail++;
                $display("FAIL dest_and_d c=%0d: got %b expected %b", c, obs, exp_vec(8'h8A, c));
            end
        end
    endtask

    task automatic test_nop_illegal();
        logic [7:0] ops [2] = '{8'h8F, 8'h10};
        for (int k = 0; k < 2; k++) begin
            tick();
            issue(ops[k], 8'h00, 1'b1);
            for (int c = 1; c <= 3; c++) begin
                tick();
                start = 1'b0;
                @(negedge clk);
                n_checks++;
                if (obs !== exp_vec(ops[k], c)) begin
                    n_fail++;
                    $display("FAIL nop_illegal instr=%h c=%0d: got %b expected %b",
                             ops[k], c, obs, exp_vec(ops[k], c));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        tick();
        issue(8'h81, 8'hFF, 1'b1);
        for (int c = 1; c <= 2*S+1; c++) begin
            tick();
            instr = 8'h8C;
            @(negedge clk);
            n_checks++;
            if ({f, busy, done} !== {3'b001, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL busy_ignore c=%0d: got f/busy/done=%b expected 00110", c, {f, busy, done});
            end
        end
        tick();
        issue(8'h86, 8'h01, 1'b1);
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b01) begin
            n_fail++;
            $display("FAIL done_cycle: got busy/done=%b expected 01", {busy, done});
        end
        tick();
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({f, busy} !== 4'b1101) begin
            n_fail++;
            $display("FAIL b2b_select: got f/busy=%b expected 1101", {f, busy});
        end
        for (int c = 2; c <= 2*S+4; c++) begin
            tick();
            @(negedge clk);
            if (done) dones++;
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d done pulses expected 1", dones);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        issue(8'h83, 8'h55, 1'b1);
        for (int c = 1; c <= S+1; c++) begin
            tick();
            start = 1'b0;
        end
        n_checks++;
        if (alu_en !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_drive: got alu_en=%b expected 1", alu_en);
        end
        #2;
        reset = 1'b1;
        #1;
        sb.delete();
        exp_cond = 3'b000;
        n_checks++;
        if (obs !== 10'b111_0000000 || cond !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_async: got outputs=%b cond=%b expected 1110000000 000", obs, cond);
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 2*S+2; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== 10'b111_0000000) begin
                n_fail++;
                $display("FAIL reset_no_strobe c=%0d: got %b expected 1110000000", c, obs);
            end
            tick();
        end
        issue(8'h84, 8'h00, 1'b1);
        for (int c = 1; c <= 2*S+3; c++) begin
            tick();
            start = 1'b0;
            @(negedge clk);
            n_checks++;
            if (obs !== exp_vec(8'h84, c)) begin
                n_fail++;
                $display("FAIL after_reset_xor c=%0d: got %b expected %b", c, obs, exp_vec(8'h84, c));
            end
        end
    endtask

`ifdef ALUSEQ_PERF_EN
    task automatic test_perf();
        logic [7:0] ops [4] = '{8'h80, 8'h8F, 8'h10, 8'h88};
        tick();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        sb.delete();
        exp_cond = 3'b000;
        n_checks++;
        if (op_count !== 16'd0) begin
            n_fail++;
            $display("FAIL perf_reset: got %h expected 0000", op_count);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            issue(ops[k], 8'h12, 1'b0);
            for (int c = 1; c <= 2*S+3; c++) begin
                tick();
                start = 1'b0;
            end
        end
        n_checks++;
        if (op_count !== 16'd3) begin
            n_fail++;
            $display("FAIL perf_count: got %0d expected 3", op_count);
        end
        for (int i = 0; i < 65540; i++) begin
            issue(8'h8F, 8'h00, 1'b0);
            tick();
        end
        start = 1'b0;
        tick();
        tick();
        n_checks++;
        if (op_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL perf_saturate: got %h expected ffff", op_count);
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_timing();
        test_dest_flags();
        test_nop_illegal();
        test_back_to_back();
        test_reset_mid();
`ifdef ALUSEQ_PERF_EN
        test_perf();
`endif
        tick();
        tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending operations expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Sequences one ALU instruction (format 1000rfff) through the 8-bit relay ALU.
- Drives the 3-bit function select (f1..f3) to the relay decode tree and waits for the relays to settle.
- Enables the ALU result onto the data bus, strobes the destination register (A or D), and latches the condition flags.
- Sits between the instruction decoder/FSM and the ALU function-select relays, the A/D register loads and the condition register.

Parameters:
- SETTLE_CYCLES, 4, clock cycles allowed for relay settling in each of the SELECT and DRIVE phases; legal range 1..255.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to execute an instruction; sampled only in IDLE.
- instr  input  8  instruction byte; captured on the accepting edge.
- result  input  8  ALU output bus (value after relay settling).
- carry_in  input  1  adder carry-out.
- f  output  3  function select; f[0]=f1, f[1]=f2, f[2]=f3.
- alu_en  output  1  gates the ALU result onto the data bus.
- ld_a  output  1  load strobe for register A.
- ld_d  output  1  load strobe for register D.
- ld_cond  output  1  condition-register update strobe.
- cond  output  3  registered flags {sign, carry, zero}.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.
- illegal  output  1  one-cycle pulse when start carries a non-ALU opcode.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset values: f=3'b111; alu_en, ld_a, ld_d, ld_cond, busy, done, illegal = 0; cond=3'b000; state=IDLE.
- Reset mid-operation: aborts immediately and no load strobe is issued.
- Function codes (fff = instr[2:0]): 000 ADD, 001 INC, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL, 111 NOP.
- Destination: instr[3]; 0 selects A, 1 selects D.
- States: IDLE, SELECT, DRIVE, LATCH.
- IDLE:
  - f=111; busy=0.
  - Accept when start=1.
  - instr[7:4]!=4'b1000: stay in IDLE; illegal=1 next cycle; no done.
  - fff=111 (NOP): stay in IDLE; done=1 next cycle; no loads; cond unchanged.
  - Otherwise: capture fff and r; go to SELECT; load settle counter with SETTLE_CYCLES-1.
- SELECT:
  - f=captured fff; busy=1; alu_en=0.
  - Lasts exactly SETTLE_CYCLES cycles, then go to DRIVE and reload the counter.
- DRIVE:
  - f held; alu_en=1.
  - Lasts exactly SETTLE_CYCLES cycles, then go to LATCH.
- LATCH (1 cycle):
  - f held; alu_en=1.
  - ld_a=~r, ld_d=r, ld_cond=1.
  - cond updates at the end of this cycle:
    - zero = (result==8'h00).
    - sign = result[7].
    - carry = carry_in for ADD/INC, 0 for all other functions.
  - Next state IDLE; done=1 in the first IDLE cycle.
- Latency: start edge at cycle 0 gives SELECT in cycles 1..S, DRIVE in S+1..2S, LATCH in 2S+1, done in 2S+2, where S=SETTLE_CYCLES.
- Back-to-back: a start asserted in the same cycle as done is accepted.
- Start while busy=1 is ignored and not queued. Changes to instr after acceptance are ignored.
- All outputs are registered (driven from state/flops). At most one of ld_a/ld_d is high in any cycle.

Optional Feature:
- Macro: ALUSEQ_PERF_EN.
- Defined:
  - Adds output op_count (16 bits).
  - Reset value 0.
  - Increments on every done pulse, including NOP; saturates at 16'hFFFF.
  - Illegal starts are not counted.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Timing: SETTLE_CYCLES=2; start with instr=8'h80 (ADD→A), result=8'h00, carry_in=1 -> SELECT cycles 1-2 with f=000; alu_en cycles 3-5; ld_a and ld_cond in cycle 5; done in cycle 6; cond={0,1,1}.
- Destination/flags: instr=8'h8A (AND→D), result=8'h80, carry_in=1 -> f=010; ld_d only (ld_a never high); cond={1,0,0}.
- NOP and illegal:
  - instr=8'h8F -> done next cycle; no alu_en or loads; cond unchanged.
  - instr=8'h10 -> illegal pulse; no done; busy stays 0.
- Busy/back-to-back: start asserted repeatedly while busy -> ignored (one done only); start in the done cycle -> second op begins next cycle.
- Reset: assert reset during DRIVE -> all outputs drop asynchronously; f=111; cond=000; no ld strobe; next start runs normally.
- Perf counter (ALUSEQ_PERF_EN): 3 ops + 1 illegal -> op_count=3; preload near saturation -> holds at 16'hFFFF.
